// File: rtl/i2c_pkg.sv
// Shared constants for the APB/I2C datapath FIFOs.
package i2c_pkg;

  localparam int unsigned I2C_TX_DWIDTH   = 32;
  localparam int unsigned I2C_RX_DWIDTH   = 16;
  localparam int unsigned I2C_FIFO_AWIDTH = 4;

  function automatic int unsigned fifo_depth(input int unsigned awidth);
    return 32'd1 << awidth;
  endfunction

endpackage

// File: rtl/fifo_i2c_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Kept separate so a technology RAM can replace it.
module fifo_i2c_mem
  import i2c_pkg::*;
#(
  parameter int unsigned DWIDTH = I2C_TX_DWIDTH,
  parameter int unsigned AWIDTH = I2C_FIFO_AWIDTH
) (
  input  logic              pclk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [fifo_depth(AWIDTH)];

  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_i2c.sv
// Show-ahead FIFO between the APB slave and the I2C core.
// Define FIFO_I2C_ERR_FLAG_EN to add sticky overflow/underflow flags with err_clr.
module fifo_i2c
  import i2c_pkg::*;
#(
  parameter int unsigned DWIDTH = I2C_TX_DWIDTH,
  parameter int unsigned AWIDTH = I2C_FIFO_AWIDTH
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH:0]   level
`ifdef FIFO_I2C_ERR_FLAG_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [AWIDTH:0] ONE = {{AWIDTH{1'b0}}, 1'b1};

  logic [AWIDTH:0] wr_ptr;
  logic [AWIDTH:0] rd_ptr;
  logic            push;
  logic            pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                 (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);

  // A push into a full FIFO is safe when a pop frees the head slot this cycle.
  assign push = wr_en && (!full || rd_en);
  assign pop  = rd_en && !empty;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      if (push && !pop)      level <= level + ONE;
      else if (pop && !push) level <= level - ONE;
    end
  end

  fifo_i2c_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .pclk    (pclk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AWIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AWIDTH-1:0]),
    .rd_data (rd_data)
  );

`ifdef FIFO_I2C_ERR_FLAG_EN
  // Set has priority over a simultaneous clear.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) overflow <= 1'b1;
      else if (err_clr)            overflow <= 1'b0;
      if (rd_en && empty)          underflow <= 1'b1;
      else if (err_clr)            underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_i2c.sv
// Directed self-checking bench for fifo_i2c (default 32x16 configuration).
module tb_fifo_i2c;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        full;
  logic        empty;
  logic [4:0]  level;
`ifdef FIFO_I2C_ERR_FLAG_EN
  logic        err_clr = 1'b0;
  logic        overflow;
  logic        underflow;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] sb[$];

  fifo_i2c #(
    .DWIDTH (32),
    .AWIDTH (4)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
`ifdef FIFO_I2C_ERR_FLAG_EN
    ,
    .err_clr   (err_clr),
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present strobes for one cycle, then return 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [31:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge pclk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    preset = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full},  32'd0);
    check("rst_level", {27'd0, level}, 32'd0);

    // 1: three pushes, in-order pops
    cyc(1'b1, 32'h11, 1'b0);
    check("t1_empty_after_push", {31'd0, empty}, 32'd0);
    cyc(1'b1, 32'h22, 1'b0);
    cyc(1'b1, 32'h33, 1'b0);
    check("t1_level", {27'd0, level}, 32'd3);
    check("t1_pop0", rd_data, 32'h11); cyc(1'b0, '0, 1'b1);
    check("t1_pop1", rd_data, 32'h22); cyc(1'b0, '0, 1'b1);
    check("t1_pop2", rd_data, 32'h33); cyc(1'b0, '0, 1'b1);
    check("t1_empty", {31'd0, empty}, 32'd1);

    // 2: fill, dropped push, drain
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 1'b0);
    check("t2_full",  {31'd0, full},  32'd1);
    check("t2_level", {27'd0, level}, 32'd16);
    cyc(1'b1, 32'hDEAD, 1'b0);
    check("t2_level_drop", {27'd0, level}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_pop%0d", i), rd_data, 32'(i));
      cyc(1'b0, '0, 1'b1);
    end
    check("t2_empty", {31'd0, empty}, 32'd1);
    check("t2_full_clr", {31'd0, full}, 32'd0);

    // 3: push+pop while full
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 1'b0);
    check("t3_head", rd_data, 32'd0);
    cyc(1'b1, 32'hAA, 1'b1);
    check("t3_level", {27'd0, level}, 32'd16);
    check("t3_full",  {31'd0, full},  32'd1);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("t3_pop%0d", i), rd_data, 32'(i));
      cyc(1'b0, '0, 1'b1);
    end
    check("t3_last", rd_data, 32'hAA);
    cyc(1'b0, '0, 1'b1);
    check("t3_empty", {31'd0, empty}, 32'd1);

    // 4: push+pop while empty
    cyc(1'b1, 32'h55, 1'b1);
    check("t4_level", {27'd0, level}, 32'd1);
    check("t4_empty", {31'd0, empty}, 32'd0);
    check("t4_data", rd_data, 32'h55);
    cyc(1'b0, '0, 1'b1);
    check("t4_empty_after", {31'd0, empty}, 32'd1);

    // 5: wrap with scoreboard, then async reset at level 7
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h1000 + 32'(i), 1'b0);
      sb.push_back(32'h1000 + 32'(i));
    end
    for (int i = 0; i < 40; i++) begin
      check($sformatf("t5_data%0d", i), rd_data, sb.pop_front());
      cyc(1'b1, 32'h2000 + 32'(i), 1'b1);
      sb.push_back(32'h2000 + 32'(i));
      check($sformatf("t5_level%0d", i), {27'd0, level}, 32'(sb.size()));
      check($sformatf("t5_flags%0d", i), {30'd0, full, empty}, 32'd0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h3000 + 32'(i), 1'b0);
    check("t5_level7", {27'd0, level}, 32'd7);
    preset = 1'b1;
    #1;
    check("t5_rst_empty", {31'd0, empty}, 32'd1);
    check("t5_rst_level", {27'd0, level}, 32'd0);
    #3 preset = 1'b0;
    @(posedge pclk);
    #1;
    check("t5_post_rst_empty", {31'd0, empty}, 32'd1);

`ifdef FIFO_I2C_ERR_FLAG_EN
    // 6: sticky error flags
    check("t6_rst_flags", {30'd0, overflow, underflow}, 32'd0);
    cyc(1'b0, '0, 1'b1);
    check("t6_underflow", {31'd0, underflow}, 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 1'b0);
    check("t6_no_ovf_yet", {31'd0, overflow}, 32'd0);
    cyc(1'b1, 32'hBEEF, 1'b0);
    check("t6_overflow", {31'd0, overflow}, 32'd1);
    err_clr = 1'b1;
    cyc(1'b0, '0, 1'b0);
    err_clr = 1'b0;
    check("t6_clr", {30'd0, overflow, underflow}, 32'd0);
    err_clr = 1'b1;
    cyc(1'b1, 32'hBEEF, 1'b0);
    err_clr = 1'b0;
    check("t6_set_wins", {31'd0, overflow}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
